rr_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational gate datapath (the lab's shared gate/ALU resource) between N requesters. It is a req/gnt/done handshake controller with rotating priority and a bounded hold time. It sits between the requester front-ends and the shared resource's operand mux: `gnt_id` drives the mux select and `busy` qualifies the resource output.

---
 rtl/rr_arbiter_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_arbiter.sv | 113 +++++++++++
 tb/tb_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM state encoding
// and an index helper that also works for non-power-of-two requester counts.
package rr_arbiter_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Index following idx, wrapping back to 0 at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from ptr,
// built as a double-width rotate followed by a priority encoder.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [IdW-1:0] pick,
    output logic           valid
);

    logic [N-1:0] rot;

    // Bit i of rot is the request i positions above ptr (mod N).
    assign rot   = N'({req, req} >> ptr);
    assign valid = |req;

    always_comb begin
        pick = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick = IdW'((32'(ptr) + 32'(i)) % N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin req/gnt/done arbiter for the shared gate datapath: rotating
// priority, bounded hold time, registered one-hot grant and index outputs.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned IdW  = $clog2(N);
    localparam int unsigned CntW = $clog2(HOLD_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IdW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic [IdW-1:0] pick;
    logic           pick_valid;
    logic           done_hit;
    logic           req_hit;
    logic           limit;

    rr_pick #(
        .N   (N),
        .IdW (IdW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign done_hit = done[gnt_id_q];
    assign req_hit  = req[gnt_id_q];
    assign limit    = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d     = StGrant;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gnt_id_d    = pick;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                end
            end
            StGrant: begin
                if (done_hit || !req_hit || limit) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    ptr_d     = IdW'(wrap_inc(32'(gnt_id_q), N));
                    // Only a release forced purely by the hold limit is a timeout.
                    timeout_d = limit && !done_hit && req_hit;
                end else if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomised scoreboard bench for rr_arbiter: a tenure-level reference model
// predicts grant/release/timeout events, a monitor matches what the DUT shows.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;
    localparam int IdW      = 2;

    localparam int EvGrant   = 0;
    localparam int EvRelease = 1;
    localparam int EvTimeout = 2;

    typedef struct {
        int kind;
        int id;
        int cyc;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IdW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    rr_arbiter #(
        .N        (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int  tests   = 0;
    int  failed  = 0;
    int  cyc     = 0;
    int  m_owner = -1;
    int  m_ptr   = 0;
    int  m_held  = 0;
    ev_t exp_q[$];

    function automatic string kname(input int kind);
        case (kind)
            EvGrant:   return "grant";
            EvRelease: return "release";
            default:   return "timeout";
        endcase
    endfunction

    function automatic void push_ev(input int kind, input int id);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endfunction

    // Reference model: one step per clock edge, in terms of owner/tenure length.
    initial begin
        int  idx;
        bit  found, d, r, lim;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_held  = 0;
                exp_q.delete();
            end else begin
                cyc++;
                if (m_owner < 0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (!found && req[idx]) begin
                            found   = 1'b1;
                            m_owner = idx;
                            m_held  = 1;
                            push_ev(EvGrant, idx);
                        end
                    end
                end else begin
                    d   = done[m_owner];
                    r   = req[m_owner];
                    lim = (m_held == HOLD_MAX);
                    if (d || !r || lim) begin
                        push_ev(EvRelease, 0);
                        if (lim && !d && r) push_ev(EvTimeout, 0);
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                        m_held  = 0;
                    end else begin
                        m_held++;
                    end
                end
            end
        end
    end

    task automatic observe(input int kind, input int id);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_%s: got id %0d at cycle %0d, required no event",
                     kname(kind), id, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.id != id || e.cyc != cyc) begin
                failed++;
                $display("FAIL event_%s: got %s id %0d at cycle %0d, required %s id %0d at cycle %0d",
                         kname(e.kind), kname(kind), id, cyc, kname(e.kind), e.id, e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge, turns DUT output changes into events.
    initial begin
        bit           prev_busy;
        logic [N-1:0] exp_g;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    tests++;
                    failed++;
                    $display("FAIL missed_%s: got nothing by cycle %0d, required id %0d at cycle %0d",
                             kname(exp_q[0].kind), cyc, exp_q[0].id, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                exp_g = busy ? (4'b0001 << gnt_id) : 4'b0000;
                tests++;
                if (gnt !== exp_g || busy !== (|gnt) || (!busy && gnt_id !== '0)) begin
                    failed++;
                    $display("FAIL grant_shape: got gnt=%b gnt_id=%0d busy=%b, required gnt=%b",
                             gnt, gnt_id, busy, exp_g);
                end
                if (busy && !prev_busy) observe(EvGrant, int'(gnt_id));
                if (!busy && prev_busy) observe(EvRelease, 0);
                if (timeout === 1'b1) observe(EvTimeout, 0);
                prev_busy = busy;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", nm, got, want);
        end
    endtask

    task automatic wait_owner(input int id, input string nm);
        int n = 0;
        while (m_owner != id && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m_owner != id) begin
            tests++;
            failed++;
            $display("FAIL %s: got owner %0d after 60 cycles, required %0d", nm, m_owner, id);
        end
    endtask

    task automatic wait_busy(input string nm);
        int n = 0;
        while (m_owner < 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m_owner < 0) begin
            tests++;
            failed++;
            $display("FAIL %s: got idle after 60 cycles, required a grant", nm);
        end
    endtask

    task automatic wait_held(input int h, input string nm);
        int n = 0;
        while (m_held != h && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m_held != h) begin
            tests++;
            failed++;
            $display("FAIL %s: got hold %0d after 60 cycles, required %0d", nm, m_held, h);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (3) @(negedge clk);
        check("reset_gnt", 32'(gnt), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_timeout", 32'(timeout), 0);
        rst_n = 1'b1;

        // Single requester, released by done.
        req = 4'b0100;
        wait_owner(2, "single_grant");
        repeat (2) @(negedge clk);
        done = 4'b0100;
        @(negedge clk);
        done = '0;
        req  = '0;
        repeat (3) @(negedge clk);

        // All requesting, each releases after two cycles.
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_busy("rotate_grant");
            @(negedge clk);
            done = 4'b0001 << m_owner;
            @(negedge clk);
            done = '0;
            wait_owner(-1, "rotate_release");
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Hold-limit timeouts, then others join and are served by rotation.
        req = 4'b0010;
        wait_owner(1, "limit_grant");
        repeat (12) @(negedge clk);
        req = 4'b1011;
        repeat (40) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Foreign done ignored; done coinciding with the limit is a normal release.
        req = 4'b0010;
        wait_owner(1, "coincide_grant");
        wait_held(2, "coincide_hold2");
        done = 4'b1000;
        @(negedge clk);
        done = '0;
        wait_held(8, "coincide_hold8");
        done = 4'b0010;
        @(negedge clk);
        done = '0;
        req  = '0;
        repeat (3) @(negedge clk);

        // Request dropped mid-tenure.
        req = 4'b0001;
        wait_owner(0, "drop_grant");
        wait_held(3, "drop_hold3");
        req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        wait_owner(2, "rst_grant");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_gnt_id", 32'(gnt_id), 0);
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_owner(3, "post_rst_grant");
        req = '0;
        repeat (3) @(negedge clk);

        // Random traffic with sticky requests and occasional done pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            done = '0;
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) done[m_owner] = 1'b1;
            if ($urandom_range(0, 7) == 0) done = done | N'($urandom_range(0, 15));
        end
        req  = '0;
        done = '0;
        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
